multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
Sequential successor to the single-cycle RV32I control decoder. It latches one instruction's opcode/funct3 and steps it through DECODE/EXECUTE/MEM/CSR/WRITEBACK states. Datapath strobes are issued only in the state that needs them, with ready/done handshakes, a bounded memory-wait timeout and illegal-instruction detection. It sits between the instruction decoder and the datapath muxes, register file, data-memory interface, CSR file and trap controller.

Parameters:
MEM_TIMEOUT, 16, cycles spent in MEM without completion before a timeout trap (minimum 2)
TIMEOUT_WIDTH, 5, width of the wait counter; must satisfy 2^TIMEOUT_WIDTH > MEM_TIMEOUT
CSR_ENABLE, 1, 1 = Zicsr decoded; 0 = SYSTEM with funct3!=0 is illegal
FENCE_DRAIN, 1, 1 = FENCE waits for write_done in EXECUTE; 0 = FENCE is a no-op

Ports:
clk  in  1  clock
reset_n  in  1  reset
instr_valid  in  1  decoder holds a valid instruction
opcode  in  7  opcode from decoder, sampled only on acceptance
funct3  in  3  funct3 from decoder, sampled only on acceptance
mem_ready  in  1  data memory access complete
write_done  in  1  pending memory writes retired
csr_ready  in  1  CSR file ready
trap_done  in  1  trap controller finished pre-trap handling
instr_ready  out  1  high in IDLE; the instruction is accepted when instr_valid is also high
jump, branch  out  1 each  as the single-cycle encoding, driven in EXECUTE only
alu_src_A_select  out  2  alu_src_select.vh encoding
alu_src_B_select  out  3  alu_src_select.vh encoding
csr_write_enable  out  1  CSR write strobe
register_file_write  out  1  RF write strobe
register_file_write_data_select  out  3  rf_wd_select.vh encoding
memory_read, memory_write  out  1 each  data memory strobes
pc_update  out  1  one-cycle pulse: commit PC (normal retire)
illegal_instruction  out  1  one-cycle pulse
mem_timeout  out  1  one-cycle pulse
busy  out  1  state != IDLE
state  out  3  debug view of the state register

Behaviour:
- Clocking and reset: one clock `clk`; reset is synchronous and active-low on `reset_n`.
- Reset values: state=IDLE, wait counter=0, latched opcode/funct3=0. Every strobe and pulse is 0. Every select is its *_NONE value.
- Outputs are Moore: decoded from the state register and the latched opcode/funct3 only. Live opcode/funct3 never reach the outputs.
- State encoding: IDLE=0, DECODE=1, EXECUTE=2, MEM=3, CSR_WAIT=4, WRITEBACK=5, TRAP=6.
- IDLE:
  - instr_ready=1.
  - If instr_valid, latch the fields and go to DECODE.
  - instr_valid is ignored in every other state.
- DECODE:
  - Illegal if any of: opcode is not one of the 11 RV32I opcodes; SYSTEM with funct3=100; SYSTEM with funct3!=0 and CSR_ENABLE=0.
  - Illegal: go to TRAP and pulse illegal_instruction in the TRAP entry cycle.
  - Otherwise go to EXECUTE.
- EXECUTE:
  - Drive jump, branch and the ALU selects per the single-cycle table. ITYPE with funct3=SRXI uses B=SHAMT. CSRRW/CSRRWI use B=NONE. Non-immediate CSR ops use A=RD1; immediate CSR ops use A=RS1; the other CSR ops use B=CSR.
  - Next state:
    - LOAD or STORE: MEM.
    - SYSTEM with funct3!=0: CSR_WAIT.
    - SYSTEM with funct3=0 (ECALL/EBREAK): TRAP.
    - FENCE with FENCE_DRAIN=1: stay in EXECUTE until write_done.
    - Otherwise: WRITEBACK.
- MEM:
  - ALU selects stay at the EXECUTE values.
  - Assert memory_read (LOAD) or memory_write (STORE) continuously.
  - The counter increments each cycle and clears on exit.
  - LOAD completes on mem_ready. STORE completes on mem_ready and write_done in the same cycle. Completion goes to WRITEBACK.
  - Timeout: if the counter equals MEM_TIMEOUT-1 and the access has not completed, go to TRAP with a mem_timeout pulse. Strobes drop on TRAP entry.
  - If completion and timeout coincide, completion wins.
- CSR_WAIT:
  - Hold csr_write_enable=1 and the CSR ALU selects until csr_ready.
  - Then go to WRITEBACK; csr_write_enable is 0 there.
- WRITEBACK:
  - Exactly one cycle, then IDLE. pulse pc_update.
  - register_file_write=1 with the matching select (LUI, ALU, JUMP, LOAD, CSR) for LUI, AUIPC, JAL, JALR, LOAD, ITYPE, RTYPE and CSR ops.
  - BRANCH, STORE and FENCE write nothing (select NONE).
- TRAP:
  - All strobes are 0. Wait for trap_done, then go to IDLE.
  - pc_update is never asserted; the trap controller redirects the PC.
  - trap_done is ignored outside TRAP.
- Latency: with acceptance edge E0, register_file_write for ALU/LUI/JAL ops is high in the cycle after E0+2.
- Reset mid-operation: the next edge forces IDLE. Any in-flight strobe drops that edge; no pc_update is issued.

Test Plan:
- Reset with reset_n=0 for 3 cycles, then ADDI (0010011, funct3=000) with instr_valid -> states 0,1,2,5,0. In EXECUTE: A=RD1, B=IMM. In WRITEBACK: register_file_write=1, select=ALU, pc_update=1 for one cycle.
- LW (0000011) with mem_ready asserted on the 4th MEM cycle -> memory_read high for exactly 4 cycles, then WRITEBACK with select=LOAD.
- SW (0100011) with mem_ready never asserted, MEM_TIMEOUT=16 -> memory_write high for 16 cycles, mem_timeout pulse, state=6. trap_done after 2 cycles -> IDLE with no pc_update.
- CSRRS (1110011, funct3=010) with csr_ready low for 3 cycles -> csr_write_enable high for 4 cycles, A=RD1, B=CSR, then RF write with select=CSR. With CSR_ENABLE=0 -> illegal_instruction pulse and TRAP.
- Opcode 1111111 -> illegal_instruction pulse, no RF or memory strobe. Also: instr_valid held during TRAP does not cause re-acceptance until IDLE.
- reset_n=0 during the 2nd MEM cycle of LW -> next cycle state=0, memory_read=0, no pc_update. A stale mem_ready afterwards is ignored.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Multicycle RV32I control sequencer. Accepts one instruction from the decoder
// in IDLE and steps it through DECODE -> EXECUTE -> (MEM | CSR_WAIT) ->
// WRITEBACK -> IDLE. Illegal instructions, ECALL/EBREAK and memory timeouts
// divert to TRAP, which is left on trap_done.
//
// All outputs are Moore outputs. They are decoded from the state register and
// the opcode/funct3 latched at acceptance. The live decoder fields never reach
// an output.
//
// Ports
//   clk, reset_n                     clock, synchronous active-low reset
//   instr_valid, opcode, funct3      instruction from decoder (fields sampled
//                                    only on acceptance)
//   mem_ready, write_done            data memory handshakes
//   csr_ready                        CSR file handshake
//   trap_done                        trap controller handshake
//   instr_ready                      high in IDLE
//   jump, branch                     control-flow flags (EXECUTE only)
//   alu_src_A_select[1:0]            A_NONE/RD1/PC/RS1
//   alu_src_B_select[2:0]            B_NONE/RD2/IMM/SHAMT/CSR
//   csr_write_enable                 CSR write strobe (CSR_WAIT)
//   register_file_write              RF write strobe (WRITEBACK)
//   register_file_write_data_select  WD_NONE/ALU/LUI/JUMP/LOAD/CSR
//   memory_read, memory_write        data memory strobes (MEM)
//   pc_update                        one-cycle pulse on normal retire
//   illegal_instruction, mem_timeout one-cycle pulses in the TRAP entry cycle
//   busy, state                      status / debug view of the state register
//
// Parameter constraints: MEM_TIMEOUT >= 2 and 2**TIMEOUT_WIDTH > MEM_TIMEOUT.
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter int unsigned MEM_TIMEOUT   = 16,
  parameter int unsigned TIMEOUT_WIDTH = 5,
  parameter bit          CSR_ENABLE    = 1'b1,
  parameter bit          FENCE_DRAIN   = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       instr_valid,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       mem_ready,
  input  logic       write_done,
  input  logic       csr_ready,
  input  logic       trap_done,
  output logic       instr_ready,
  output logic       jump,
  output logic       branch,
  output logic [1:0] alu_src_A_select,
  output logic [2:0] alu_src_B_select,
  output logic       csr_write_enable,
  output logic       register_file_write,
  output logic [2:0] register_file_write_data_select,
  output logic       memory_read,
  output logic       memory_write,
  output logic       pc_update,
  output logic       illegal_instruction,
  output logic       mem_timeout,
  output logic       busy,
  output logic [2:0] state
);

  // RV32I major opcodes
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_SRXI   = 3'b101;

  // ALU operand selects
  localparam logic [1:0] A_NONE = 2'd0, A_RD1 = 2'd1, A_PC = 2'd2, A_RS1 = 2'd3;
  localparam logic [2:0] B_NONE = 3'd0, B_RD2 = 3'd1, B_IMM = 3'd2,
                         B_SHAMT = 3'd3, B_CSR = 3'd4;
  // Register-file write-data selects
  localparam logic [2:0] WD_NONE = 3'd0, WD_ALU = 3'd1, WD_LUI = 3'd2,
                         WD_JUMP = 3'd3, WD_LOAD = 3'd4, WD_CSR = 3'd5;

  localparam logic [TIMEOUT_WIDTH-1:0] WAIT_LAST = TIMEOUT_WIDTH'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_CSR_WAIT  = 3'd4,
    S_WRITEBACK = 3'd5,
    S_TRAP      = 3'd6
  } state_t;

  state_t                   state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0] wait_count;
  logic [6:0]               op_q;
  logic [2:0]               f3_q;
  logic                     illegal_q, illegal_d;
  logic                     timeout_q, timeout_d;

  // Static decode of the latched instruction
  logic [1:0] dec_a;
  logic [2:0] dec_b;
  logic [2:0] dec_wd;
  logic       dec_jump, dec_branch, dec_legal;
  logic       mem_done;

  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    dec_a      = A_NONE;
    dec_b      = B_NONE;
    dec_wd     = WD_NONE;
    dec_jump   = 1'b0;
    dec_branch = 1'b0;
    dec_legal  = 1'b1;
    case (op_q)
      OP_LUI:   dec_wd = WD_LUI;
      OP_AUIPC: begin dec_a = A_PC;  dec_b = B_IMM; dec_wd = WD_ALU;  end
      OP_JAL:   begin dec_a = A_PC;  dec_b = B_IMM; dec_wd = WD_JUMP; dec_jump = 1'b1; end
      OP_JALR:  begin dec_a = A_RD1; dec_b = B_IMM; dec_wd = WD_JUMP; dec_jump = 1'b1; end
      OP_BRANCH: begin dec_a = A_RD1; dec_b = B_RD2; dec_branch = 1'b1; end
      OP_LOAD:  begin dec_a = A_RD1; dec_b = B_IMM; dec_wd = WD_LOAD; end
      OP_STORE: begin dec_a = A_RD1; dec_b = B_IMM; end
      OP_ITYPE: begin
        dec_a  = A_RD1;
        dec_b  = (f3_q == F3_SRXI) ? B_SHAMT : B_IMM;
        dec_wd = WD_ALU;
      end
      OP_RTYPE: begin dec_a = A_RD1; dec_b = B_RD2; dec_wd = WD_ALU; end
      OP_FENCE: ;
      OP_SYSTEM: begin
        if (f3_q != 3'b000) begin
          // funct3[2] selects the zimm (rs1 field) forms; CSRRW/CSRRWI do not
          // need the old CSR value on the B port.
          dec_a  = f3_q[2] ? A_RS1 : A_RD1;
          dec_b  = (f3_q[1:0] == 2'b01) ? B_NONE : B_CSR;
          dec_wd = WD_CSR;
        end
        if (f3_q == 3'b100 || (f3_q != 3'b000 && !CSR_ENABLE)) dec_legal = 1'b0;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // A store only completes once the write has also retired.
  assign mem_done = (op_q == OP_STORE) ? (mem_ready && write_done) : mem_ready;

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE:   if (instr_valid) state_d = S_DECODE;
      S_DECODE: begin
        if (!dec_legal) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        case (op_q)
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_SYSTEM:         state_d = (f3_q != 3'b000) ? S_CSR_WAIT : S_TRAP;
          OP_FENCE:          if (!FENCE_DRAIN || write_done) state_d = S_WRITEBACK;
          default:           state_d = S_WRITEBACK;
        endcase
      end
      S_MEM: begin
        // Completion is tested first so it wins over a same-cycle timeout.
        if (mem_done) begin
          state_d = S_WRITEBACK;
        end else if (wait_count == WAIT_LAST) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end
      end
      S_CSR_WAIT:  if (csr_ready) state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_IDLE;
      S_TRAP:      if (trap_done) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the latched opcode/funct3 are reset too; the decode above reads
  // them in every state, so they must never be X.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wait_count <= '0;
      op_q       <= '0;
      f3_q       <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      if (state_q == S_IDLE && instr_valid) begin
        op_q <= opcode;
        f3_q <= funct3;
      end
      if (state_q == S_MEM && state_d == S_MEM) wait_count <= wait_count + 1'b1;
      else                                      wait_count <= '0;
    end
  end

  // Moore outputs
  always_comb begin
    jump                            = 1'b0;
    branch                          = 1'b0;
    alu_src_A_select                = A_NONE;
    alu_src_B_select                = B_NONE;
    csr_write_enable                = 1'b0;
    register_file_write             = 1'b0;
    register_file_write_data_select = WD_NONE;
    memory_read                     = 1'b0;
    memory_write                    = 1'b0;
    pc_update                       = 1'b0;
    case (state_q)
      S_EXECUTE: begin
        jump             = dec_jump;
        branch           = dec_branch;
        alu_src_A_select = dec_a;
        alu_src_B_select = dec_b;
      end
      S_MEM: begin
        alu_src_A_select = dec_a;
        alu_src_B_select = dec_b;
        memory_read      = (op_q == OP_LOAD);
        memory_write     = (op_q == OP_STORE);
      end
      S_CSR_WAIT: begin
        alu_src_A_select = dec_a;
        alu_src_B_select = dec_b;
        csr_write_enable = 1'b1;
      end
      S_WRITEBACK: begin
        pc_update                       = 1'b1;
        register_file_write             = (dec_wd != WD_NONE);
        register_file_write_data_select = dec_wd;
      end
      default: ;
    endcase
  end

  assign instr_ready         = (state_q == S_IDLE);
  assign busy                = (state_q != S_IDLE);
  assign state               = state_q;
  assign illegal_instruction = illegal_q;
  assign mem_timeout         = timeout_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Directed testbench for multicycle_control_unit. One task per scenario,
// each with inline comparisons against hand-computed values. A second
// instance with CSR_ENABLE=0 covers the disabled-Zicsr decode. Inputs change
// and outputs are sampled on the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                         OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_ITYPE = 7'b0010011,
                         OP_RTYPE = 7'b0110011, OP_FENCE = 7'b0001111,
                         OP_SYSTEM = 7'b1110011;
  localparam logic [1:0] A_NONE = 2'd0, A_RD1 = 2'd1, A_PC = 2'd2, A_RS1 = 2'd3;
  localparam logic [2:0] B_NONE = 3'd0, B_RD2 = 3'd1, B_IMM = 3'd2,
                         B_SHAMT = 3'd3, B_CSR = 3'd4;
  localparam logic [2:0] WD_NONE = 3'd0, WD_ALU = 3'd1, WD_LUI = 3'd2,
                         WD_JUMP = 3'd3, WD_LOAD = 3'd4, WD_CSR = 3'd5;

  logic       clk = 1'b0;
  logic       reset_n, instr_valid, mem_ready, write_done, csr_ready, trap_done;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       nc_instr_valid, nc_trap_done;

  logic       instr_ready, jump, branch, csr_we, rf_write, mem_read, mem_write;
  logic       pc_update, illegal, mem_to, busy;
  logic [1:0] a_sel;
  logic [2:0] b_sel, wd_sel, state;

  logic       nc_instr_ready, nc_jump, nc_branch, nc_csr_we, nc_rf_write;
  logic       nc_mem_read, nc_mem_write, nc_pc_update, nc_illegal, nc_mem_to, nc_busy;
  logic [1:0] nc_a_sel;
  logic [2:0] nc_b_sel, nc_wd_sel, nc_state;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] got, want;
  int          cnt;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid),
    .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
    .write_done(write_done), .csr_ready(csr_ready), .trap_done(trap_done),
    .instr_ready(instr_ready), .jump(jump), .branch(branch),
    .alu_src_A_select(a_sel), .alu_src_B_select(b_sel),
    .csr_write_enable(csr_we), .register_file_write(rf_write),
    .register_file_write_data_select(wd_sel), .memory_read(mem_read),
    .memory_write(mem_write), .pc_update(pc_update),
    .illegal_instruction(illegal), .mem_timeout(mem_to), .busy(busy),
    .state(state)
  );

  multicycle_control_unit #(.CSR_ENABLE(1'b0)) dut_nocsr (
    .clk(clk), .reset_n(reset_n), .instr_valid(nc_instr_valid),
    .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
    .write_done(write_done), .csr_ready(csr_ready), .trap_done(nc_trap_done),
    .instr_ready(nc_instr_ready), .jump(nc_jump), .branch(nc_branch),
    .alu_src_A_select(nc_a_sel), .alu_src_B_select(nc_b_sel),
    .csr_write_enable(nc_csr_we), .register_file_write(nc_rf_write),
    .register_file_write_data_select(nc_wd_sel), .memory_read(nc_mem_read),
    .memory_write(nc_mem_write), .pc_update(nc_pc_update),
    .illegal_instruction(nc_illegal), .mem_timeout(nc_mem_to), .busy(nc_busy),
    .state(nc_state)
  );

  // Present an instruction for one acceptance edge, then scramble the live
  // fields so any leak of them into the outputs becomes visible.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3);
    opcode = op; funct3 = f3; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0; opcode = 7'h7f; funct3 = 3'h4;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    got  = {state, instr_ready, busy, jump, branch, a_sel, b_sel, csr_we, rf_write,
            wd_sel, mem_read, mem_write, pc_update, illegal, mem_to};
    want = {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, A_NONE, B_NONE, 1'b0, 1'b0,
            WD_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL reset: got %h want %h", got, want); end
    got  = {nc_state, nc_instr_ready, nc_illegal, nc_pc_update};
    want = {3'd0, 1'b1, 1'b0, 1'b0};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL reset_nocsr: got %h want %h", got, want); end
    reset_n = 1'b1;
  endtask

  // Register/ALU/branch ops: DECODE, EXECUTE, WRITEBACK, IDLE.
  task automatic test_simple(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic ej, input logic eb, input logic [1:0] ea,
                             input logic [2:0] ebs, input logic ew, input logic [2:0] ewd);
    issue(op, f3);
    got = {state, instr_ready, busy}; want = {3'd1, 1'b0, 1'b1};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL %s decode: got %h want %h", name, got, want); end
    @(negedge clk);
    got  = {state, jump, branch, a_sel, b_sel, rf_write, pc_update};
    want = {3'd2, ej, eb, ea, ebs, 1'b0, 1'b0};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL %s execute: got %h want %h", name, got, want); end
    @(negedge clk);
    got  = {state, rf_write, wd_sel, pc_update, jump, branch};
    want = {3'd5, ew, ewd, 1'b1, 1'b0, 1'b0};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL %s writeback: got %h want %h", name, got, want); end
    @(negedge clk);
    got = {state, pc_update, rf_write}; want = {3'd0, 1'b0, 1'b0};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL %s idle: got %h want %h", name, got, want); end
  endtask

  task automatic test_load(input int ready_at);
    issue(OP_LOAD, 3'b010);
    @(negedge clk);
    got = {state, a_sel, b_sel, mem_read}; want = {3'd2, A_RD1, B_IMM, 1'b0};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL load execute: got %h want %h", got, want); end
    @(negedge clk);
    got = {state, a_sel, b_sel, mem_read, mem_write}; want = {3'd3, A_RD1, B_IMM, 1'b1, 1'b0};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL load mem entry: got %h want %h", got, want); end
    cnt = 0;
    for (int i = 0; i < 40 && state == 3'd3; i++) begin
      if (mem_read) cnt++;
      if (cnt == ready_at) mem_ready = 1'b1;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    vectors++;
    if (cnt != ready_at) begin miscompares++; $display("FAIL load read cycles: got %0d want %0d", cnt, ready_at); end
    got  = {state, mem_read, mem_to, rf_write, wd_sel, pc_update};
    want = {3'd5, 1'b0, 1'b0, 1'b1, WD_LOAD, 1'b1};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL load writeback (ready_at %0d): got %h want %h", ready_at, got, want); end
    @(negedge clk);
    vectors++;
    if (state !== 3'd0) begin miscompares++; $display("FAIL load idle: got %0d want 0", state); end
  endtask

  task automatic test_store_timeout();
    issue(OP_STORE, 3'b010);
    repeat (2) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 40 && state == 3'd3; i++) begin
      if (mem_write) cnt++;
      @(negedge clk);
    end
    vectors++;
    if (cnt != 16) begin miscompares++; $display("FAIL store timeout write cycles: got %0d want 16", cnt); end
    got  = {state, mem_to, mem_write, illegal, pc_update, rf_write};
    want = {3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL store timeout trap entry: got %h want %h", got, want); end
    @(negedge clk);
    got = {state, mem_to, pc_update}; want = {3'd6, 1'b0, 1'b0};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL store timeout trap hold: got %h want %h", got, want); end
    trap_done = 1'b1;
    @(negedge clk);
    trap_done = 1'b0;
    got = {state, pc_update, instr_ready}; want = {3'd0, 1'b0, 1'b1};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL store timeout release: got %h want %h", got, want); end
  endtask

  // mem_ready alone must not complete a store; write_done joins on the 3rd cycle.
  task automatic test_store_complete();
    issue(OP_STORE, 3'b000);
    repeat (2) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 40 && state == 3'd3; i++) begin
      if (mem_write) cnt++;
      mem_ready = 1'b1;
      if (cnt == 3) write_done = 1'b1;
      @(negedge clk);
    end
    mem_ready = 1'b0; write_done = 1'b0;
    vectors++;
    if (cnt != 3) begin miscompares++; $display("FAIL store write cycles: got %0d want 3", cnt); end
    got = {state, mem_write, rf_write, wd_sel, pc_update}; want = {3'd5, 1'b0, 1'b0, WD_NONE, 1'b1};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL store writeback: got %h want %h", got, want); end
    @(negedge clk);
  endtask

  task automatic test_csr(input string name, input logic [2:0] f3, input logic [1:0] ea,
                          input logic [2:0] eb, input int low);
    issue(OP_SYSTEM, f3);
    @(negedge clk);
    got = {state, a_sel, b_sel, csr_we}; want = {3'd2, ea, eb, 1'b0};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL %s execute: got %h want %h", name, got, want); end
    @(negedge clk);
    got = {state, a_sel, b_sel, csr_we}; want = {3'd4, ea, eb, 1'b1};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL %s csr_wait: got %h want %h", name, got, want); end
    cnt = 0;
    for (int i = 0; i < 40 && state == 3'd4; i++) begin
      if (csr_we) cnt++;
      if (cnt == low + 1) csr_ready = 1'b1;
      @(negedge clk);
    end
    csr_ready = 1'b0;
    vectors++;
    if (cnt != low + 1) begin miscompares++; $display("FAIL %s csr_we cycles: got %0d want %0d", name, cnt, low + 1); end
    got = {state, csr_we, rf_write, wd_sel, pc_update}; want = {3'd5, 1'b0, 1'b1, WD_CSR, 1'b1};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL %s writeback: got %h want %h", name, got, want); end
    @(negedge clk);
  endtask

  task automatic test_csr_disabled();
    opcode = OP_SYSTEM; funct3 = 3'b010; nc_instr_valid = 1'b1;
    @(negedge clk);
    nc_instr_valid = 1'b0; opcode = 7'h7f;
    @(negedge clk);
    got = {nc_state, nc_illegal, nc_csr_we, nc_rf_write}; want = {3'd6, 1'b1, 1'b0, 1'b0};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL nocsr trap entry: got %h want %h", got, want); end
    @(negedge clk);
    got = {nc_state, nc_illegal}; want = {3'd6, 1'b0};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL nocsr trap hold: got %h want %h", got, want); end
    nc_trap_done = 1'b1;
    @(negedge clk);
    nc_trap_done = 1'b0;
    got = {nc_state, nc_pc_update, state}; want = {3'd0, 1'b0, 3'd0};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL nocsr release: got %h want %h", got, want); end
  endtask

  // Illegal decode, with instr_valid held throughout TRAP.
  task automatic test_illegal(input string name, input logic [6:0] op, input logic [2:0] f3);
    issue(op, f3);
    opcode = OP_ITYPE; funct3 = 3'b000; instr_valid = 1'b1;
    @(negedge clk);
    got  = {state, illegal, rf_write, mem_read, mem_write, csr_we, pc_update};
    want = {3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL %s trap entry: got %h want %h", name, got, want); end
    repeat (2) @(negedge clk);
    got = {state, illegal, instr_ready}; want = {3'd6, 1'b0, 1'b0};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL %s no reaccept in trap: got %h want %h", name, got, want); end
    trap_done = 1'b1;
    @(negedge clk);
    trap_done = 1'b0;
    got = {state, instr_ready, pc_update}; want = {3'd0, 1'b1, 1'b0};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL %s trap release: got %h want %h", name, got, want); end
    @(negedge clk);
    instr_valid = 1'b0;
    vectors++;
    if (state !== 3'd1) begin miscompares++; $display("FAIL %s accept after trap: got %0d want 1", name, state); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ecall();
    issue(OP_SYSTEM, 3'b000);
    @(negedge clk);
    trap_done = 1'b1;
    @(negedge clk);
    got = {state, illegal, pc_update, rf_write}; want = {3'd6, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL ecall trap: got %h want %h", got, want); end
    @(negedge clk);
    trap_done = 1'b0;
    vectors++;
    if (state !== 3'd0) begin miscompares++; $display("FAIL ecall release: got %0d want 0", state); end
  endtask

  task automatic test_fence();
    issue(OP_FENCE, 3'b000);
    repeat (3) @(negedge clk);
    got = {state, rf_write, pc_update}; want = {3'd2, 1'b0, 1'b0};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL fence drain hold: got %h want %h", got, want); end
    write_done = 1'b1;
    @(negedge clk);
    write_done = 1'b0;
    got = {state, rf_write, wd_sel, pc_update}; want = {3'd5, 1'b0, WD_NONE, 1'b1};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL fence writeback: got %h want %h", got, want); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    issue(OP_LOAD, 3'b010);
    repeat (3) @(negedge clk);
    got = {state, mem_read}; want = {3'd3, 1'b1};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL reset_mid mem2: got %h want %h", got, want); end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    mem_ready = 1'b1;
    got = {state, mem_read, pc_update, rf_write}; want = {3'd0, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL reset_mid abort: got %h want %h", got, want); end
    @(negedge clk);
    mem_ready = 1'b0;
    got = {state, mem_read, pc_update, rf_write}; want = {3'd0, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL reset_mid stale ready: got %h want %h", got, want); end
  endtask

  initial begin
    reset_n = 1'b0; instr_valid = 1'b0; opcode = '0; funct3 = '0;
    mem_ready = 1'b0; write_done = 1'b0; csr_ready = 1'b0; trap_done = 1'b0;
    nc_instr_valid = 1'b0; nc_trap_done = 1'b0;

    test_reset();
    test_simple("addi",  OP_ITYPE,  3'b000, 1'b0, 1'b0, A_RD1,  B_IMM,   1'b1, WD_ALU);
    test_simple("srai",  OP_ITYPE,  3'b101, 1'b0, 1'b0, A_RD1,  B_SHAMT, 1'b1, WD_ALU);
    test_simple("add",   OP_RTYPE,  3'b000, 1'b0, 1'b0, A_RD1,  B_RD2,   1'b1, WD_ALU);
    test_simple("lui",   OP_LUI,    3'b000, 1'b0, 1'b0, A_NONE, B_NONE,  1'b1, WD_LUI);
    test_simple("auipc", OP_AUIPC,  3'b000, 1'b0, 1'b0, A_PC,   B_IMM,   1'b1, WD_ALU);
    test_simple("jal",   OP_JAL,    3'b000, 1'b1, 1'b0, A_PC,   B_IMM,   1'b1, WD_JUMP);
    test_simple("jalr",  OP_JALR,   3'b000, 1'b1, 1'b0, A_RD1,  B_IMM,   1'b1, WD_JUMP);
    test_simple("beq",   OP_BRANCH, 3'b000, 1'b0, 1'b1, A_RD1,  B_RD2,   1'b0, WD_NONE);
    test_load(4);
    test_load(16);
    test_store_timeout();
    test_store_complete();
    test_csr("csrrs",  3'b010, A_RD1, B_CSR,  3);
    test_csr("csrrwi", 3'b101, A_RS1, B_NONE, 0);
    test_csr_disabled();
    test_illegal("op7f",    7'b1111111, 3'b000);
    test_illegal("sys_f3_4", OP_SYSTEM, 3'b100);
    test_ecall();
    test_fence();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary in time");
    $fatal(1);
  end

endmodule
